// File: rtl/wb_regfile.sv
// Writeback stage: selects the final result, writes the 32x32 GPR file, serves two
// bypassed decode read ports, and emits a registered commit trace plus commit counter.
module wb_regfile #(
    parameter int LINK_OFFSET = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      pc,
    input  logic [4:0]       regaddr,
    input  logic [31:0]      alures,
    input  logic [31:0]      memres,
    input  logic             memToReg,
    input  logic             regWrite,
    input  logic             jump,
    input  logic [31:0]      cp0data,
    input  logic             cp0read,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic [31:0]      wb_data,
    output logic             wb_we,
    output logic             commit_valid,
    output logic [31:0]      commit_pc,
    output logic [4:0]       commit_addr,
    output logic [31:0]      commit_data,
    output logic [CNT_W-1:0] commit_count
);

    logic [31:0] r_gpr [32];
    logic        r_stall_q;
    logic [31:0] w_wb_data;
    logic        w_wb_we;

    always_comb begin
        w_wb_data = alures;
        if (jump)
            w_wb_data = pc + 32'(LINK_OFFSET);
        else if (cp0read)
            w_wb_data = cp0data;
        else if (memToReg)
            w_wb_data = memres;
    end

    // A held instruction (stall seen last cycle) was already committed on its first cycle.
    assign w_wb_we = regWrite & (regaddr != 5'd0) & ~r_stall_q & reset;

    assign wb_data = w_wb_data;
    assign wb_we   = w_wb_we;

    always_comb begin
        rs_data = r_gpr[rs_addr];
        if (rs_addr == 5'd0)
            rs_data = 32'd0;
        else if (w_wb_we && (rs_addr == regaddr))
            rs_data = w_wb_data;
    end

    always_comb begin
        rt_data = r_gpr[rt_addr];
        if (rt_addr == 5'd0)
            rt_data = 32'd0;
        else if (w_wb_we && (rt_addr == regaddr))
            rt_data = w_wb_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                r_gpr[i] <= 32'd0;
            r_stall_q    <= 1'b0;
            commit_valid <= 1'b0;
            commit_pc    <= 32'd0;
            commit_addr  <= 5'd0;
            commit_data  <= 32'd0;
            commit_count <= '0;
        end else begin
            r_stall_q    <= stall;
            commit_valid <= w_wb_we;
            if (w_wb_we) begin
                r_gpr[regaddr] <= w_wb_data;
                commit_pc      <= pc;
                commit_addr    <= regaddr;
                commit_data    <= w_wb_data;
                commit_count   <= commit_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps followed by randomized
// traffic compared against an architectural register-file model.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] pc;
    logic [4:0]  regaddr;
    logic [31:0] alures;
    logic [31:0] memres;
    logic        memToReg;
    logic        regWrite;
    logic        jump;
    logic [31:0] cp0data;
    logic        cp0read;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic [31:0] commit_count;

    wb_regfile #(.LINK_OFFSET(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc), .regaddr(regaddr),
        .alures(alures), .memres(memres), .memToReg(memToReg), .regWrite(regWrite),
        .jump(jump), .cp0data(cp0data), .cp0read(cp0read), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
        .wb_we(wb_we), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_addr(commit_addr), .commit_data(commit_data), .commit_count(commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Architectural model: register contents, commit trace, and whether the
    // instruction now in WB is a re-presentation of one already retired.
    logic [31:0] m_gpr [32];
    logic [31:0] m_count;
    logic        m_cv;
    logic [31:0] m_cpc;
    logic [4:0]  m_caddr;
    logic [31:0] m_cdata;
    logic        m_repeat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_result();
        if (jump)          return pc + 32'd8;
        else if (cp0read)  return cp0data;
        else if (memToReg) return memres;
        else               return alures;
    endfunction

    function automatic logic exp_we();
        return regWrite && (regaddr != 5'd0) && !m_repeat && reset;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0)                      return 32'd0;
        if (exp_we() && a == regaddr)       return exp_result();
        return m_gpr[a];
    endfunction

    // One cycle: inputs already driven after a negedge.
    task automatic cycle();
        logic [31:0] d;
        logic        we;
        #1;
        d  = exp_result();
        we = exp_we();
        check("wb_data", wb_data, d);
        check("wb_we", {31'd0, wb_we}, {31'd0, we});
        check("rs_data", rs_data, exp_read(rs_addr));
        check("rt_data", rt_data, exp_read(rt_addr));
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_count = 0; m_cv = 0; m_cpc = 0; m_caddr = 0; m_cdata = 0; m_repeat = 0;
        end else begin
            m_cv = we;
            if (we) begin
                m_gpr[regaddr] = d;
                m_count = m_count + 1;
                m_cpc = pc; m_caddr = regaddr; m_cdata = d;
            end
            m_repeat = stall;
        end
        #1;
        check("commit_valid", {31'd0, commit_valid}, {31'd0, m_cv});
        check("commit_count", commit_count, m_count);
        check("commit_pc", commit_pc, m_cpc);
        check("commit_addr", {27'd0, commit_addr}, {27'd0, m_caddr});
        check("commit_data", commit_data, m_cdata);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; pc = 0; regaddr = 0; alures = 0; memres = 0; memToReg = 0;
        regWrite = 0; jump = 0; cp0data = 0; cp0read = 0; rs_addr = 0; rt_addr = 0;
    endtask

    logic [31:0] cnt_before;

    initial begin
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_count = 0; m_cv = 0; m_cpc = 0; m_caddr = 0; m_cdata = 0; m_repeat = 0;
        idle_inputs();
        reset = 0;
        @(negedge clk);
        cycle();
        cycle();
        reset = 1;

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i);
            cycle();
        end

        // ALU write with same-cycle bypass, then architectural read-back.
        regWrite = 1; regaddr = 5; alures = 32'h1234; rs_addr = 5; rt_addr = 6;
        #1 check("bypass_5", rs_data, 32'h1234);
        cycle();
        check("commit_1", commit_count, 32'd1);
        regWrite = 0; rs_addr = 5;
        cycle();

        // Link write beats cp0 select; then cp0 select alone.
        regWrite = 1; jump = 1; cp0read = 1; cp0data = 32'hDEAD; pc = 32'h3000; regaddr = 31;
        #1 check("link_data", wb_data, 32'h3008);
        cycle();
        jump = 0;
        cycle();
        regWrite = 0; cp0read = 0; rs_addr = 31;
        cycle();
        check("gpr31_cp0", rs_data, 32'hDEAD);

        // Load held by a three-cycle stall commits exactly once.
        cnt_before = m_count;
        regWrite = 1; memToReg = 1; memres = 32'hCAFEF00D; regaddr = 8; stall = 1; rs_addr = 8;
        cycle();
        cycle();
        cycle();
        stall = 0;
        cycle();
        check("stall_once", commit_count, cnt_before + 32'd1);
        regWrite = 0; memToReg = 0;
        cycle();
        check("gpr8", rs_data, 32'hCAFEF00D);

        // Writes to $0 are dropped.
        regWrite = 1; regaddr = 0; alures = 32'hFFFFFFFF; rs_addr = 0;
        cycle();

        // Reset arriving mid-stall clears the file and the hold state.
        regaddr = 3; alures = 32'h55;
        cycle();
        stall = 1; regWrite = 1;
        cycle();
        reset = 0;
        cycle();
        reset = 1; stall = 0; regWrite = 0; rs_addr = 3;
        cycle();
        check("gpr3_cleared", rs_data, 32'd0);
        regWrite = 1; regaddr = 9; alures = 32'h77; rt_addr = 9;
        cycle();
        check("fresh_after_rst", commit_count, 32'd1);
        regWrite = 0;

        // Randomized traffic; a stalled instruction is re-presented unchanged.
        for (int n = 0; n < 400; n++) begin
            if (!m_repeat) begin
                pc       = $urandom;
                regaddr  = 5'($urandom_range(0, 31));
                alures   = $urandom;
                memres   = $urandom;
                cp0data  = $urandom;
                memToReg = 1'($urandom_range(0, 1));
                cp0read  = ($urandom_range(0, 3) == 0);
                jump     = ($urandom_range(0, 3) == 0);
                regWrite = ($urandom_range(0, 3) != 0);
            end
            stall   = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 99) != 0);
            rs_addr = ($urandom_range(0, 2) == 0) ? regaddr : 5'($urandom_range(0, 31));
            rt_addr = ($urandom_range(0, 2) == 0) ? regaddr : 5'($urandom_range(0, 31));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline-register interface.
- Selects the final writeback value, writes the 32x32 GPR file, and serves the two decode-stage read ports with same-cycle write bypass.
- Suppresses duplicate writes while the WB register holds its contents during a stall.
- Emits a registered one-cycle commit trace and a commit counter for the bench.

Parameters:
- LINK_OFFSET, 8, value added to pc for link writes (jal/jalr).
- CNT_W, 32, width of commit_count.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (reset==0 at posedge resets).
- stall  input  1  same stall that holds the MEM/WB register; registered internally.
- pc  input  32  PC of the instruction in WB.
- regaddr  input  5  destination register.
- alures  input  32  ALU result.
- memres  input  32  load data.
- memToReg  input  1  select memres.
- regWrite  input  1  instruction writes a GPR.
- jump  input  1  link write; data is pc+LINK_OFFSET.
- cp0data  input  32  CP0 read data (mfc0).
- cp0read  input  1  select cp0data.
- rs_addr  input  5  read port A address.
- rt_addr  input  5  read port B address.
- rs_data  output  32  read port A data (combinational).
- rt_data  output  32  read port B data (combinational).
- wb_data  output  32  selected writeback value (combinational), used for forwarding.
- wb_we  output  1  effective write enable this cycle (combinational).
- commit_valid  output  1  one-cycle pulse: a write committed in the previous cycle.
- commit_pc  output  32  PC of the committed write.
- commit_addr  output  5  register written.
- commit_data  output  32  value written.
- commit_count  output  CNT_W  total committed writes since reset.

Behaviour:
- Data select, fixed priority:
  - jump: pc+LINK_OFFSET, 32-bit wrap.
  - else cp0read: cp0data.
  - else memToReg: memres.
  - else alures.
- stall_q: register, stall sampled each posedge; reset value 0.
- Fresh instruction in WB: stall_q==0. When stall_q==1, the WB inputs are the same instruction as the previous cycle, which was already committed.
- Write enable: wb_we = regWrite & (regaddr!=0) & ~stall_q & reset.
  - Current stall does not gate writes; the first cycle of a held instruction still commits.
- GPR write: on posedge when wb_we=1, gpr[regaddr] <= wb_data. gpr[0] always reads 0 and is never written.
- Read ports:
  - rs_data = 0 if rs_addr==0.
  - else wb_data if wb_we & rs_addr==regaddr (bypass).
  - else gpr[rs_addr].
  - rt_data follows the same rules with rt_addr.
- Commit trace, registered:
  - On posedge, commit_valid <= wb_we.
  - When wb_we=1: commit_pc/addr/data <= pc/regaddr/wb_data.
  - Otherwise the commit_pc/addr/data fields hold their previous values.
- commit_count increments by 1 on every posedge with wb_we=1 and wraps at 2^CNT_W.
- Reset (reset==0 at posedge), any time including mid-stall:
  - all gpr to 0, stall_q 0, commit_valid 0, commit_pc 0, commit_addr 0, commit_data 0, commit_count 0.
  - No write occurs in the reset cycle.
- Simultaneous write and read of the same register: the reader gets the new value (bypass). Writes to $0 neither bypass nor commit.
- Multiple select flags set at once: the priority above applies and is not an error.

Test Plan:
- Reset then read all 32 addresses -> every read is 0; commit_count=0; commit_valid=0.
- regWrite=1, regaddr=5, alures=0x1234, memToReg=0, rs_addr=5 -> rs_data=0x1234 in the same cycle (bypass). Next cycle: commit_valid=1, commit_addr=5, commit_data=0x1234, commit_count=1; gpr[5]=0x1234.
- jump=1, cp0read=1, pc=0x3000, regaddr=31 -> wb_data=0x3008 and gpr[31]=0x3008. Repeat with jump=0 and cp0data=0xDEAD -> gpr[31]=0xDEAD.
- memToReg=1, memres=0xCAFEF00D, regaddr=8; hold stall=1 for 3 cycles with inputs unchanged -> exactly one write; commit_count +1 only; commit_valid high for one cycle only.
- regWrite=1, regaddr=0, alures=0xFFFFFFFF -> wb_we=0; rs_addr=0 reads 0; commit_count unchanged.
- Write gpr[3]=0x55, assert stall, apply reset=0 mid-stall -> gpr[3]=0, stall_q=0. The first fresh write after release commits normally with commit_count=1.
